// File: rtl/dot_accumulator_if.sv
// Stream bundle for dot_accumulator: incoming term channel and outgoing result channel.
interface dot_accumulator_if #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 40
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/dot_accumulator.sv
// Sums COUNT consecutive accepted terms into one wide result and queues
// completed results in a 2-entry FIFO with a registered head.
module dot_accumulator #(
  parameter int WIDTH     = 32,
  parameter int COUNT     = 4,
  parameter int ACC_WIDTH = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  dot_accumulator_if.slave     bus,
  output logic [7:0]           term_cnt
);
  localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, LAST} state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc, sum, head, tail;
  logic [1:0]           fcnt;
  logic                 accept, push, pop;

  // in_ready depends only on registered state, never on in_valid/out_ready
  assign bus.in_ready  = !(state == LAST && fcnt == 2'd2);
  assign bus.out_valid = (fcnt != 2'd0);
  assign bus.out_data  = head;

  assign accept = bus.in_valid && bus.in_ready && !clear;
  assign push   = accept && (state == LAST);
  assign pop    = bus.out_valid && bus.out_ready;
  assign sum    = acc + ACC_WIDTH'(bus.in_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      term_cnt <= '0;
    end else if (clear) begin
      state    <= IDLE;
      acc      <= '0;
      term_cnt <= '0;
    end else if (accept) begin
      if (state == LAST) begin
        state    <= IDLE;
        acc      <= '0;
        term_cnt <= '0;
      end else begin
        state    <= (term_cnt + 8'd1 == LAST_CNT) ? LAST : ACCUM;
        acc      <= sum;
        term_cnt <= term_cnt + 8'd1;
      end
    end
  end

  // head is the visible entry; tail only holds data when two results are queued
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      fcnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fcnt == 2'd0) head <= sum;
          else              tail <= sum;
          fcnt <= fcnt + 2'd1;
        end
        2'b01: begin
          if (fcnt == 2'd2) head <= tail;
          fcnt <= fcnt - 2'd1;
        end
        2'b11: begin
          if (fcnt == 2'd1) head <= sum;
          else begin
            head <= tail;
            tail <= sum;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_accumulator.sv
// Directed and randomized checks of dot_accumulator against a queue-based model.
module tb_dot_accumulator;
  localparam int WIDTH     = 32;
  localparam int COUNT     = 4;
  localparam int ACC_WIDTH = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [7:0] term_cnt;

  dot_accumulator_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus();

  dot_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT), .ACC_WIDTH(ACC_WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .bus      (bus),
    .term_cnt (term_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: completed sums in order, plus the running partial group
  logic [ACC_WIDTH-1:0] q[$];
  logic [ACC_WIDTH-1:0] psum;
  int                   pcnt;
  bit                   m_acc;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_rdy();
    return !(pcnt == COUNT - 1 && q.size() == 2);
  endfunction

  // called at a negedge: check outputs against the model, drive, step one edge
  task automatic cyc(bit v, logic [WIDTH-1:0] d, bit rdy, bit clr);
    logic [ACC_WIDTH-1:0] s;
    chk("term_cnt", 64'(term_cnt), 64'(pcnt));
    chk("in_ready", 64'(bus.in_ready), 64'(m_rdy()));
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    if (q.size() != 0) chk("out_data", 64'(bus.out_data), 64'(q[0]));
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
    clear         = clr;
    m_acc = v && m_rdy() && !clr;
    @(posedge clk);
    if (q.size() != 0 && rdy) void'(q.pop_front());
    if (clr) begin
      psum = '0;
      pcnt = 0;
    end else if (m_acc) begin
      s = psum + ACC_WIDTH'(d);
      if (pcnt == COUNT - 1) begin
        q.push_back(s);
        psum = '0;
        pcnt = 0;
      end else begin
        psum = s;
        pcnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic send(logic [WIDTH-1:0] d, bit rdy);
    for (int t = 0; t < 20; t++) begin
      cyc(1'b1, d, rdy, 1'b0);
      if (m_acc) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL send_timeout: term %0h not accepted within 20 cycles", d);
  endtask

  task automatic drain();
    for (int t = 0; t < 3; t++) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    psum = '0;
    pcnt = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_term_cnt", 64'(term_cnt), 64'd0);
    reset = 1'b0;

    // basic group
    send(6, 1); send(8, 1); send(1, 1); send(2, 1);
    chk("basic_valid", 64'(bus.out_valid), 64'd1);
    chk("basic_sum", 64'(bus.out_data), 64'd17);
    drain();

    // sink stall: two results buffered, third group blocks on its final term
    send(6, 0); send(8, 0); send(1, 0); send(2, 0);
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    send(5, 0); send(5, 0); send(5, 0);
    cyc(1'b1, 5, 1'b0, 1'b0);
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    chk("stall_head", 64'(bus.out_data), 64'd17);
    send(5, 1);
    drain();

    // final term accepted on the same edge as a pop
    send(6, 0); send(8, 0); send(1, 0); send(2, 0);
    send(3, 0); send(3, 0); send(3, 0);
    send(4, 1);
    chk("pushpop_valid", 64'(bus.out_valid), 64'd1);
    chk("pushpop_data", 64'(bus.out_data), 64'd13);
    drain();

    // clear mid-group discards the partial sum and the coincident term
    send(6, 1); send(8, 1);
    cyc(1'b1, 100, 1'b1, 1'b1);
    send(1, 1); send(1, 1); send(1, 1); send(1, 1);
    chk("clear_sum", 64'(bus.out_data), 64'd4);
    drain();

    // max terms
    for (int i = 0; i < COUNT; i++) send(32'hFFFF_FFFF, 0);
    chk("max_sum", 64'(bus.out_data), 64'h03_FFFF_FFFC);
    drain();

    // async reset with a partial group and a full FIFO
    for (int i = 0; i < COUNT; i++) send(1, 0);
    for (int i = 0; i < COUNT; i++) send(2, 0);
    send(7, 0); send(7, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_data", 64'(bus.out_data), 64'd0);
    chk("arst_term_cnt", 64'(term_cnt), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    q.delete();
    psum = '0;
    pcnt = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < COUNT; i++) send(3, 0);
    chk("post_reset_sum", 64'(bus.out_data), 64'd12);
    drain();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [WIDTH-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? $urandom() : WIDTH'($urandom_range(0, 255));
      cyc($urandom_range(0, 9) < 7, d, 1'($urandom_range(0, 1)),
          $urandom_range(0, 29) == 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dot_accumulator.md
Name: dot_accumulator

Overview:
- Downstream consumer of the `pipeline` dot-product stage.
- Takes the stream of 32-bit partial results C, sums COUNT consecutive accepted terms into one wide result, and buffers completed results in a 2-entry FIFO.
- Upstream keeps streaming while the sink stalls; backpressure is asserted only when a completed sum would have nowhere to go.

Parameters:
- WIDTH, 32, width of incoming term (matches C).
- COUNT, 4, terms per accumulated result; legal range 2..256.
- ACC_WIDTH, 40, width of accumulator and result; must be >= WIDTH+clog2(COUNT).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous discard of the partial accumulation.
- in_valid  input  1  in_data holds a term.
- in_ready  output  1  block can accept a term this cycle.
- in_data  input  WIDTH  term (unsigned), driven from C.
- out_valid  output  1  FIFO head holds a result.
- out_ready  input  1  sink accepts the head this cycle.
- out_data  output  ACC_WIDTH  FIFO head result.
- term_cnt  output  8  terms accumulated in the current group (0..COUNT-1).

Behaviour:
- Reset (async assert, released synchronously to clk):
  - acc=0, term_cnt=0, FIFO empty.
  - out_valid=0, out_data=0, in_ready=1.
- Transfers:
  - A term is accepted on a rising edge where in_valid && in_ready.
  - A result is popped on a rising edge where out_valid && out_ready.
- Accumulation, unsigned, zero-extended to ACC_WIDTH:
  - Accepted non-final term (term_cnt<COUNT-1): acc<=acc+in_data, term_cnt<=term_cnt+1.
  - Accepted final term (term_cnt==COUNT-1): acc+in_data is pushed into the FIFO, then acc<=0 and term_cnt<=0.
- FSM with states IDLE, ACCUM and LAST:
  - IDLE: term_cnt==0.
  - ACCUM: 0<term_cnt<COUNT-1.
  - LAST: term_cnt==COUNT-1.
  - Each accepted term advances the state; the final term returns it to IDLE.
- in_ready = !(term_cnt==COUNT-1 && fifo_count==2). There is no combinational path from out_ready or in_valid to in_ready.
- Latency:
  - If the FIFO is empty, the final term accepted at edge k gives out_valid=1 with the sum on out_data immediately after edge k (1 cycle).
  - out_data is a registered head; it holds stable while out_valid && !out_ready.
- FIFO:
  - 2 entries, in-order.
  - Simultaneous push and pop keeps the count unchanged and advances the head correctly.
  - Pop when empty is impossible because out_valid=0.
- Full boundary:
  - With fifo_count==2 and the block in LAST, in_ready=0 even if out_ready=1 in that cycle.
  - in_ready returns to 1 the cycle after a pop.
- Overflow: wrap modulo 2^ACC_WIDTH. With legal parameters, no overflow is possible.
- clear:
  - acc<=0, term_cnt<=0; the FIFO is untouched.
  - A term presented in the same cycle as clear is discarded even if in_valid && in_ready.
  - clear has priority over accumulation.
- Reset mid-operation: partial sum and FIFO contents are lost immediately, and out_valid drops asynchronously.
- in_data is ignored when in_valid=0; out_ready is ignored when out_valid=0.

Test Plan:
- Basic sum, COUNT=4, out_ready=1:
  - Stimulus: terms 6,8,1,2 on consecutive cycles.
  - Response: out_valid pulses 1 cycle after the 4th accept, out_data=17, term_cnt sequence 0,1,2,3,0.
- Sink stall, out_ready=0:
  - Stimulus: three groups (6,8,1,2), (1,1,1,1), (5,5,5,5).
  - Response: results 17 and 4 are buffered; in_ready=0 once the third group reaches term_cnt=3.
  - Then raise out_ready: pops give 17, then 4, then 20, in order. in_ready returns 1 the cycle after the first pop.
- Simultaneous push and pop:
  - Stimulus: FIFO holds 1 entry (17); final term of the next group is accepted in the same cycle as a pop.
  - Response: fifo_count stays 1, and the next out_data is the new sum.
- clear mid-group:
  - Stimulus: 6,8, then clear together with in_valid (in_data=100), then 1,1,1,1.
  - Response: no result for the aborted group; next out_data=4.
- Async reset mid-operation:
  - Stimulus: assert reset between clock edges with term_cnt=2 and 2 FIFO entries.
  - Response: out_valid=0 and out_data=0 immediately, term_cnt=0, in_ready=1. After release, 3,3,3,3 yields 12.
- Max value:
  - Stimulus: four terms 0xFFFFFFFF.
  - Response: out_data=0x03FFFFFFFC (no truncation at ACC_WIDTH=40).
